rst_seq_ctrl: RTL and testbench

- Power-up and recovery reset sequencer in the `sys_clk` domain, directly downstream of the clock/reset generator.
- Consumes `sys_rst` and the Ethernet PLL lock status.
- Drives the external Ethernet PHY reset pin, then releases core-logic reset, then data-plane reset, in a fixed timed order.
- Re-runs the sequence on PLL lock loss or on a CSR soft-reset request.

---
 rtl/rst_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_rst_seq_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Power-up / recovery reset sequencer: PHY reset pulse, settle wait, then staged
// release of core and data-plane resets. The sequence re-runs on PLL lock loss or a soft-reset request.
module rst_seq_ctrl #(
  parameter int PHY_RST_CYCLES    = 800000,
  parameter int PHY_SETTLE_CYCLES = 4000000,
  parameter int STAGE_GAP_CYCLES  = 16,
  parameter int CNT_W             = 23
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       eth_locked_async,
  input  logic       soft_rst_req,
  output logic       phy_rst_n,
  output logic       core_rst,
  output logic       dp_rst,
  output logic       seq_done,
  output logic [2:0] seq_state,
  output logic [7:0] lock_loss_cnt
);

  localparam logic [2:0] ST_WAIT_LOCK  = 3'd0;
  localparam logic [2:0] ST_PHY_RST    = 3'd1;
  localparam logic [2:0] ST_PHY_SETTLE = 3'd2;
  localparam logic [2:0] ST_REL_CORE   = 3'd3;
  localparam logic [2:0] ST_RUN        = 3'd4;

  localparam logic [CNT_W-1:0] PHY_RST_LAST    = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHY_SETTLE_LAST = CNT_W'(PHY_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_GAP_LAST  = CNT_W'(STAGE_GAP_CYCLES - 1);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [CNT_W-1:0] cnt;
  logic             lock_meta;
  logic             lock_s;
  logic             lock_loss;
  logic             phy_rst_n_d;
  logic             core_rst_d;
  logic             dp_rst_d;
  logic             seq_done_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= eth_locked_async;
      lock_s    <= lock_meta;
    end
  end

  // State register; the counter restarts whenever the state changes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= ST_WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) cnt <= '0;
      else                     cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    lock_loss = 1'b0;
    if ((state == ST_PHY_RST) || (state == ST_PHY_SETTLE) ||
        (state == ST_REL_CORE) || (state == ST_RUN))
      lock_loss = !lock_s;
  end

  // Lock loss outranks soft reset, which outranks timed progression.
  always_comb begin
    next_state = state;
    case (state)
      ST_WAIT_LOCK:  if (lock_s) next_state = ST_PHY_RST;
      ST_PHY_RST: begin
        if (lock_loss)                 next_state = ST_WAIT_LOCK;
        else if (cnt == PHY_RST_LAST)  next_state = ST_PHY_SETTLE;
      end
      ST_PHY_SETTLE: begin
        if (lock_loss)                   next_state = ST_WAIT_LOCK;
        else if (cnt == PHY_SETTLE_LAST) next_state = ST_REL_CORE;
      end
      ST_REL_CORE: begin
        if (lock_loss)                  next_state = ST_WAIT_LOCK;
        else if (cnt == STAGE_GAP_LAST) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (lock_loss)         next_state = ST_WAIT_LOCK;
        else if (soft_rst_req) next_state = ST_PHY_RST;
      end
      default: next_state = ST_WAIT_LOCK;
    endcase
  end

  always_comb begin
    phy_rst_n_d = 1'b0;
    core_rst_d  = 1'b1;
    dp_rst_d    = 1'b1;
    seq_done_d  = 1'b0;
    case (next_state)
      ST_PHY_SETTLE: phy_rst_n_d = 1'b1;
      ST_REL_CORE: begin
        phy_rst_n_d = 1'b1;
        core_rst_d  = 1'b0;
      end
      ST_RUN: begin
        phy_rst_n_d = 1'b1;
        core_rst_d  = 1'b0;
        dp_rst_d    = 1'b0;
        seq_done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are registered from next_state so they line up with seq_state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      phy_rst_n     <= 1'b0;
      core_rst      <= 1'b1;
      dp_rst        <= 1'b1;
      seq_done      <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      phy_rst_n <= phy_rst_n_d;
      core_rst  <= core_rst_d;
      dp_rst    <= dp_rst_d;
      seq_done  <= seq_done_d;
      if (lock_loss && (lock_loss_cnt != 8'hff))
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed bring-up/recovery scenarios, then random
// lock/soft-reset traffic, all checked against an elapsed-time sequence model.
module tb_rst_seq_ctrl;
  localparam int PR = 8;
  localparam int PS = 12;
  localparam int SG = 4;
  localparam int CW = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       eth_locked_async;
  logic       soft_rst_req;
  logic       phy_rst_n;
  logic       core_rst;
  logic       dp_rst;
  logic       seq_done;
  logic [2:0] seq_state;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  rst_seq_ctrl #(
    .PHY_RST_CYCLES(PR), .PHY_SETTLE_CYCLES(PS),
    .STAGE_GAP_CYCLES(SG), .CNT_W(CW)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .eth_locked_async(eth_locked_async),
    .soft_rst_req(soft_rst_req), .phy_rst_n(phy_rst_n), .core_rst(core_rst),
    .dp_rst(dp_rst), .seq_done(seq_done), .seq_state(seq_state),
    .lock_loss_cnt(lock_loss_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a running sequence is described only by cycles elapsed since it began.
  bit m_valid = 1'b0;
  bit m_s1, m_s2, m_in_seq;
  int m_el, m_loss;

  function automatic int stage(input int el);
    if (el < PR) return 1;
    if (el < PR + PS) return 2;
    if (el < PR + PS + SG) return 3;
    return 4;
  endfunction

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      m_s1 = 0; m_s2 = 0; m_in_seq = 0; m_el = 0; m_loss = 0; m_valid = 1;
    end else begin
      if (!m_in_seq) begin
        if (m_s2) begin m_in_seq = 1; m_el = 0; end
      end else if (!m_s2) begin
        m_in_seq = 0;
        if (m_loss < 255) m_loss++;
      end else if (stage(m_el) == 4 && soft_rst_req) begin
        m_el = 0;
      end else if (m_el < 1000) begin
        m_el++;
      end
      m_s2 = m_s1;
      m_s1 = eth_locked_async;
    end
  end

  always @(negedge sys_clk) begin
    int es;
    if (m_valid) begin
      es = m_in_seq ? stage(m_el) : 0;
      chk("model_state", 32'(seq_state), 32'(es));
      chk("model_phy_rst_n", 32'(phy_rst_n), 32'(es >= 2));
      chk("model_core_rst", 32'(core_rst), 32'(es < 3));
      chk("model_dp_rst", 32'(dp_rst), 32'(es < 4));
      chk("model_seq_done", 32'(seq_done), 32'(es == 4));
      chk("model_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
      chk("inv_dp_core", 32'(!dp_rst && core_rst), 32'd0);
      chk("inv_core_phy", 32'(!core_rst && !phy_rst_n), 32'd0);
    end
  end

  task automatic adv(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  initial begin
    int hold;
    sys_rst = 1'b1; eth_locked_async = 1'b0; soft_rst_req = 1'b0;
    adv(3);
    chk("rst_state", 32'(seq_state), 32'd0);
    chk("rst_phy", 32'(phy_rst_n), 32'd0);
    chk("rst_core_dp", 32'({core_rst, dp_rst, seq_done}), 32'b110);
    sys_rst = 1'b0;
    adv(2);
    chk("idle_wait", 32'(seq_state), 32'd0);

    // Nominal bring-up: lock raised in cycle T.
    eth_locked_async = 1'b1;
    adv(2);  chk("nom_T2_state", 32'(seq_state), 32'd0);
    adv(1);  chk("nom_T3_state", 32'(seq_state), 32'd1);
    adv(7);  chk("nom_T10_phy", 32'(phy_rst_n), 32'd0);
    adv(1);  chk("nom_T11_phy", 32'(phy_rst_n), 32'd1);
    adv(11); chk("nom_T22_core", 32'(core_rst), 32'd1);
    adv(1);  chk("nom_T23_core", 32'(core_rst), 32'd0);
    adv(3);  chk("nom_T26_dp", 32'(dp_rst), 32'd1);
    adv(1);  chk("nom_T27_dp", 32'(dp_rst), 32'd0);
    chk("nom_T27_done", 32'(seq_done), 32'd1);
    chk("nom_loss", 32'(lock_loss_cnt), 32'd0);

    // Lock loss in RUN, then re-lock.
    eth_locked_async = 1'b0;
    adv(2);  chk("loss_t2_state", 32'(seq_state), 32'd4);
    adv(1);  chk("loss_t3_state", 32'(seq_state), 32'd0);
    chk("loss_t3_resets", 32'({phy_rst_n, core_rst, dp_rst}), 32'b011);
    chk("loss_cnt1", 32'(lock_loss_cnt), 32'd1);
    eth_locked_async = 1'b1;
    adv(27); chk("relock_run", 32'(seq_state), 32'd4);

    // Soft reset in RUN.
    soft_rst_req = 1'b1;
    adv(1); soft_rst_req = 1'b0;
    chk("soft_state", 32'(seq_state), 32'd1);
    chk("soft_resets", 32'({phy_rst_n, core_rst, dp_rst}), 32'b011);
    adv(7); chk("soft_hold", 32'(seq_state), 32'd1);
    adv(1); chk("soft_settle", 32'(seq_state), 32'd2);
    adv(2); soft_rst_req = 1'b1;
    adv(1); soft_rst_req = 1'b0;
    chk("soft_in_settle_ignored", 32'(seq_state), 32'd2);
    adv(17); chk("soft_back_run", 32'(seq_state), 32'd4);

    // Lock loss and soft request in the same cycle.
    eth_locked_async = 1'b0;
    adv(2); soft_rst_req = 1'b1;
    adv(1); soft_rst_req = 1'b0;
    chk("simul_state", 32'(seq_state), 32'd0);
    chk("simul_cnt2", 32'(lock_loss_cnt), 32'd2);

    // Saturation of the lock-loss counter.
    for (int i = 0; i < 300; i++) begin
      eth_locked_async = 1'b1;
      adv(3);
      eth_locked_async = 1'b0;
      adv(3);
    end
    chk("sat_cnt", 32'(lock_loss_cnt), 32'd255);

    // sys_rst during PHY_SETTLE.
    eth_locked_async = 1'b1;
    adv(13); chk("mid_settle", 32'(seq_state), 32'd2);
    sys_rst = 1'b1;
    adv(1);
    chk("mid_rst_state", 32'(seq_state), 32'd0);
    chk("mid_rst_outs", 32'({phy_rst_n, core_rst, dp_rst, seq_done}), 32'b0110);
    chk("mid_rst_cnt", 32'(lock_loss_cnt), 32'd0);
    sys_rst = 1'b0;

    // Random lock toggling and soft pulses.
    hold = 0;
    for (int c = 0; c < 10000; c++) begin
      if (hold == 0) begin
        eth_locked_async = ~eth_locked_async;
        hold = $urandom_range(1, 80);
      end else begin
        hold--;
      end
      soft_rst_req = ($urandom_range(0, 39) == 0);
      adv(1);
    end
    soft_rst_req = 1'b0;
    adv(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
